game_soc_usb_rst_pio: RTL and testbench
=======================================

GAME_SOC_USB_RST_PIO -- requirements
Module: game_soc_usb_rst_pio

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock
- reset  in  1  async active-high reset
- address  in  2  Avalon-MM slave word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe, qualified by chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data
- out_port  out  1  registered drive to the USB controller reset/control pin
- irq  out  1  level interrupt, pulse-complete
REQ-003 The block SHALL have one parameter: PULSE_LEN_RST, default 16'd1000, the reset value of PULSE_LEN.

Function
REQ-004 The register map SHALL be:
- 0 DATA: bit0, read/write.
- 1 PULSE_LEN: bits15:0, read/write; upper bits read 0.
- 2 CTRL/STATUS: write bit0=1 starts a pulse, write bit1=1 clears irq; read bit0=busy, bit1=irq.
- 3 SETCLR: write bit0=1 sets DATA, write bit1=1 clears DATA, both=1 leaves DATA unchanged; reads 0.
REQ-005 A write SHALL occur on any rising clk edge where chipselect=1 and write_n=0.
REQ-006 readdata SHALL be registered every cycle from the address present at that edge (one-cycle latency, no read strobe); unused bits SHALL read 0.
REQ-007 The FSM SHALL have states IDLE and PULSE; busy=1 exactly in PULSE.
REQ-008 A start write in IDLE with PULSE_LEN!=0 SHALL:
- enter PULSE;
- load the 16-bit down-counter with PULSE_LEN at that same edge.
REQ-009 In PULSE the counter SHALL decrement each edge; at the edge where it equals 1 the FSM SHALL return to IDLE and set irq.
REQ-010 out_port SHALL equal DATA XOR busy, registered and updated on the same edge as the state or DATA change, so the output is inverted for exactly PULSE_LEN cycles.
REQ-011 A start write with PULSE_LEN=0, or while in PULSE, SHALL be ignored: no restart and no counter reload.
REQ-012 A write to PULSE_LEN during PULSE SHALL update the register but SHALL NOT affect the running count.
REQ-013 A write to DATA or SETCLR during PULSE SHALL take effect immediately; out_port follows REQ-010.
REQ-014 If an irq-clear write and pulse completion occur on the same edge, irq SHALL be 1 (set wins).
REQ-015 If a start bit and an irq-clear bit are written together, the block SHALL perform both.

Reset
REQ-016 On reset the block SHALL set:
- DATA=0, PULSE_LEN=PULSE_LEN_RST
- state=IDLE, counter=0
- irq=0, out_port=0, readdata=0
REQ-017 Reset asserted during PULSE SHALL abort the pulse immediately and asynchronously, with no irq.

Structure
REQ-018 A shared package SHALL hold:
- the address constants ADDR_DATA=0, ADDR_PULSE_LEN=1, ADDR_CTRL=2, ADDR_SETCLR=3;
- the CTRL bit indices;
- the FSM state enum.
REQ-019 The counter and FSM SHALL be one sub-module, game_soc_usb_rst_pulse_timer, with ports start, len[15:0], busy and done.

Verification
REQ-020 Reset then read each address -> readdata=0, 1000, 0, 0; out_port=0.
REQ-021 Write DATA=1, then PULSE_LEN=5, then start -> out_port=0 for exactly 5 cycles, then 1; irq=1; busy=0; read CTRL=0x2.
REQ-022 Start with PULSE_LEN=0 -> no change on out_port, busy or irq.
REQ-023 During a 10-cycle pulse, re-start at cycle 3 and write PULSE_LEN=2 -> the pulse still lasts 10 cycles total.
REQ-024 Write irq-clear on the exact completion edge -> irq=1; a later clear -> irq=0.
REQ-025 Assert reset mid-pulse -> out_port=0, busy=0 and irq=0 immediately, with no clock required.

Source files
------------

// File: rtl/game_soc_usb_rst_pio_pkg.sv
// Shared definitions for the USB controller reset/control PIO: register map,
// CTRL/STATUS/SETCLR bit positions and the pulse FSM state type.
package game_soc_usb_rst_pio_pkg;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_PULSE_LEN = 2'd1;
  localparam logic [1:0] ADDR_CTRL      = 2'd2;
  localparam logic [1:0] ADDR_SETCLR    = 2'd3;

  localparam int CTRL_START_BIT   = 0;
  localparam int CTRL_IRQ_CLR_BIT = 1;
  localparam int STAT_BUSY_BIT    = 0;
  localparam int STAT_IRQ_BIT     = 1;
  localparam int SETCLR_SET_BIT   = 0;
  localparam int SETCLR_CLR_BIT   = 1;

  localparam int LEN_W = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_PULSE = 1'b1
  } pulse_state_e;

  // Set and clear together cancel out and keep the current value.
  function automatic logic setclr_apply(input logic cur, input logic set, input logic clr);
    logic res;
    res = cur;
    if (set && !clr) res = 1'b1;
    else if (clr && !set) res = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/game_soc_usb_rst_pulse_timer.sv
// Pulse FSM with a 16-bit down-counter: a start in IDLE with a non-zero length
// holds busy for exactly len cycles, flagging done on the final cycle.
//
// state    | meaning
// ST_IDLE  | no pulse running, start accepted when len != 0
// ST_PULSE | pulse running, counter decrements every edge, exits at count 1
module game_soc_usb_rst_pulse_timer
  import game_soc_usb_rst_pio_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done
);

  pulse_state_e     state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Starts during a pulse fall through the PULSE branch untouched: no restart, no reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && (len != '0)) begin
          state_d = ST_PULSE;
          cnt_d   = len;
        end
      end
      ST_PULSE: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1}) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    if (state_q == ST_PULSE) begin
      busy = 1'b1;
      done = (cnt_q == {{(LEN_W-1){1'b0}}, 1'b1});
    end
  end

endmodule

// File: rtl/game_soc_usb_rst_pio.sv
// Avalon-MM PIO driving the USB controller reset/control pin, with a timed
// inversion pulse, a completion interrupt and registered one-cycle readback.
module game_soc_usb_rst_pio
  import game_soc_usb_rst_pio_pkg::*;
#(
  parameter logic [LEN_W-1:0] PULSE_LEN_RST = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        out_port,
  output logic        irq
);

  logic             data_q, data_d;
  logic [LEN_W-1:0] pulse_len_q;
  logic             irq_q;
  logic             wr_en, wr_data, wr_len, wr_ctrl, wr_setclr;
  logic             start, irq_clr;
  logic             busy, done, busy_nxt;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign unused_wdata = ^writedata[31:LEN_W];

  assign wr_en     = chipselect && !write_n;
  assign wr_data   = wr_en && (address == ADDR_DATA);
  assign wr_len    = wr_en && (address == ADDR_PULSE_LEN);
  assign wr_ctrl   = wr_en && (address == ADDR_CTRL);
  assign wr_setclr = wr_en && (address == ADDR_SETCLR);

  assign start   = wr_ctrl && writedata[CTRL_START_BIT];
  assign irq_clr = wr_ctrl && writedata[CTRL_IRQ_CLR_BIT];

  game_soc_usb_rst_pulse_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len   (pulse_len_q),
    .busy  (busy),
    .done  (done)
  );

  // Busy as it will be after this edge, so out_port flips on the same edge as the FSM.
  assign busy_nxt = busy ? !done : (start && (pulse_len_q != '0));

  always_comb begin
    data_d = data_q;
    if (wr_data)
      data_d = writedata[0];
    else if (wr_setclr)
      data_d = setclr_apply(data_q, writedata[SETCLR_SET_BIT], writedata[SETCLR_CLR_BIT]);
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:      rd_mux[0] = data_q;
      ADDR_PULSE_LEN: rd_mux[LEN_W-1:0] = pulse_len_q;
      ADDR_CTRL: begin
        rd_mux[STAT_BUSY_BIT] = busy;
        rd_mux[STAT_IRQ_BIT]  = irq_q;
      end
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q      <= 1'b0;
      pulse_len_q <= PULSE_LEN_RST;
      irq_q       <= 1'b0;
      out_port    <= 1'b0;
      readdata    <= '0;
    end else begin
      data_q   <= data_d;
      out_port <= data_d ^ busy_nxt;
      readdata <= rd_mux;
      if (wr_len) pulse_len_q <= writedata[LEN_W-1:0];
      // Completion beats a simultaneous clear.
      if (done)         irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_game_soc_usb_rst_pio.sv
// Bench for game_soc_usb_rst_pio: directed register traffic, a cycle-level
// behavioural model checked every cycle, and literal checks on key points.
module tb_game_soc_usb_rst_pio;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic        out_port;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  game_soc_usb_rst_pio #(.PULSE_LEN_RST(16'd1000)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining pulse cycles, register contents, irq flag.
  int          m_rem;
  logic        m_data, m_irq;
  logic [15:0] m_len;
  logic [31:0] exp_rd;
  logic        exp_out;

  logic m_wr, m_start, m_clr, m_data_nx;
  int   m_rem_nx;

  assign m_wr    = chipselect && !write_n;
  assign m_start = m_wr && address == 2'd2 && writedata[0];
  assign m_clr   = m_wr && address == 2'd2 && writedata[1];

  always_comb begin
    m_data_nx = m_data;
    if (m_wr && address == 2'd0) m_data_nx = writedata[0];
    else if (m_wr && address == 2'd3 && writedata[1:0] == 2'b01) m_data_nx = 1'b1;
    else if (m_wr && address == 2'd3 && writedata[1:0] == 2'b10) m_data_nx = 1'b0;
    m_rem_nx = m_rem;
    if (m_rem > 0) m_rem_nx = m_rem - 1;
    else if (m_start && m_len != 16'd0) m_rem_nx = int'(m_len);
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_rem   <= 0;
      m_data  <= 1'b0;
      m_irq   <= 1'b0;
      m_len   <= 16'd1000;
      exp_rd  <= 32'd0;
      exp_out <= 1'b0;
    end else begin
      case (address)
        2'd0:    exp_rd <= {31'd0, m_data};
        2'd1:    exp_rd <= {16'd0, m_len};
        2'd2:    exp_rd <= {30'd0, m_irq, m_rem > 0};
        default: exp_rd <= 32'd0;
      endcase
      m_rem   <= m_rem_nx;
      m_data  <= m_data_nx;
      exp_out <= m_data_nx ^ (m_rem_nx > 0);
      if (m_rem == 1) m_irq <= 1'b1;
      else if (m_clr) m_irq <= 1'b0;
      if (m_wr && address == 2'd1) m_len <= writedata[15:0];
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("model_readdata", readdata, exp_rd);
      check("model_out_port", {31'd0, out_port}, {31'd0, exp_out});
      check("model_irq", {31'd0, irq}, {31'd0, m_irq});
    end
  end

  // Length of the most recent run of out_port=0.
  int run_len = 0;
  int last_run = 0;
  always @(negedge clk) begin
    if (reset) run_len <= 0;
    else if (out_port == 1'b0) run_len <= run_len + 1;
    else if (run_len != 0) begin
      last_run <= run_len;
      run_len  <= 0;
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    address = a;
    @(negedge clk);
    check(name, readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_out_port", {31'd0, out_port}, 32'd0);
    check("reset_readdata", readdata, 32'd0);
    reset = 1'b0;

    // Reset values of the register map
    rd_chk("rst_data", 2'd0, 32'd0);
    rd_chk("rst_len", 2'd1, 32'd1000);
    rd_chk("rst_ctrl", 2'd2, 32'd0);
    rd_chk("rst_setclr", 2'd3, 32'd0);
    check("rst_out_port2", {31'd0, out_port}, 32'd0);

    // 5-cycle pulse with DATA=1
    wr(2'd0, 32'd1);
    check("data1_out", {31'd0, out_port}, 32'd1);
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd1);
    repeat (8) @(negedge clk);
    check("pulse5_len", last_run, 5);
    check("pulse5_out", {31'd0, out_port}, 32'd1);
    check("pulse5_irq", {31'd0, irq}, 32'd1);
    rd_chk("pulse5_ctrl", 2'd2, 32'h2);
    wr(2'd2, 32'd2);
    check("clr_irq", {31'd0, irq}, 32'd0);

    // Start with zero length is ignored
    wr(2'd1, 32'd0);
    wr(2'd2, 32'd1);
    repeat (3) @(negedge clk);
    check("len0_out", {31'd0, out_port}, 32'd1);
    check("len0_irq", {31'd0, irq}, 32'd0);
    rd_chk("len0_ctrl", 2'd2, 32'd0);

    // 10-cycle pulse with restart and PULSE_LEN rewrite mid-pulse
    wr(2'd1, 32'd10);
    wr(2'd2, 32'd1);
    wr(2'd2, 32'd1);
    wr(2'd1, 32'd2);
    repeat (12) @(negedge clk);
    check("pulse10_len", last_run, 10);
    check("pulse10_irq", {31'd0, irq}, 32'd1);
    rd_chk("pulse10_newlen", 2'd1, 32'd2);

    // Clear on the completion edge: set wins
    wr(2'd2, 32'd2);
    wr(2'd2, 32'd1);
    wr(2'd2, 32'd2);
    check("clr_on_done_irq", {31'd0, irq}, 32'd1);
    check("clr_on_done_out", {31'd0, out_port}, 32'd1);

    // Start and clear together
    wr(2'd2, 32'd3);
    check("start_clr_irq", {31'd0, irq}, 32'd0);
    check("start_clr_out", {31'd0, out_port}, 32'd0);
    repeat (3) @(negedge clk);
    check("start_clr_done", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'd2);
    check("late_clr_irq", {31'd0, irq}, 32'd0);

    // DATA via SETCLR during an 8-cycle pulse
    wr(2'd1, 32'd8);
    wr(2'd2, 32'd1);
    wr(2'd3, 32'd2);
    check("setclr_clr_out", {31'd0, out_port}, 32'd1);
    wr(2'd3, 32'd3);
    check("setclr_both_out", {31'd0, out_port}, 32'd1);
    wr(2'd3, 32'd1);
    check("setclr_set_out", {31'd0, out_port}, 32'd0);
    repeat (4) @(negedge clk);
    check("setclr_done_irq", {31'd0, irq}, 32'd1);
    check("setclr_done_out", {31'd0, out_port}, 32'd1);

    // Asynchronous reset mid-pulse
    wr(2'd0, 32'd0);
    wr(2'd1, 32'd10);
    wr(2'd2, 32'd1);
    repeat (3) @(negedge clk);
    check("pre_reset_out", {31'd0, out_port}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out", {31'd0, out_port}, 32'd0);
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    check("async_rst_rd", readdata, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_chk("post_rst_ctrl", 2'd2, 32'd0);
    rd_chk("post_rst_len", 2'd1, 32'd1000);
    rd_chk("post_rst_data", 2'd0, 32'd0);
    repeat (12) @(negedge clk);
    check("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
